// File: rtl/imem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_responder_pkg
// Description : Shared widths and FSM state encoding for the instruction
//               memory line-fill responder.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_responder_pkg;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 16;
    localparam int LINE_WORDS = 8;
    localparam int OFFS_W     = 3;
    localparam int LINE_W     = ADDR_W - OFFS_W;
    localparam int WAIT_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } imem_state_e;

endpackage
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
// Module      : imem_ram
// Description : 1R1W program memory, synchronous read, read-old-data on a
//               same-address collision. Only the read register is reset.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_ram
    import imem_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:(1 << ADDR_W) - 1];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The read register holds whenever no read is issued, so the last word stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : imem_responder
// Description : Serves instruction-cache line fills from program memory as
//               an 8-word burst after a configurable number of wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int LINE_WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              mreq,
    input  logic [ADDR_W-1:0] address_in,
    output logic [DATA_W-1:0] data_out,
    output logic              ready,
    output logic              busy,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data
);

    localparam logic [1:0] c_ST_IDLE  = ST_IDLE;
    localparam logic [1:0] c_ST_WAIT  = ST_WAIT;
    localparam logic [1:0] c_ST_BURST = ST_BURST;
    localparam logic [1:0] c_ST_DONE  = ST_DONE;

    localparam logic [OFFS_W-1:0] c_LAST_OFFS = OFFS_W'(LINE_WORDS - 1);
    localparam logic [WAIT_W-1:0] c_WAIT_LAST =
        (WAIT_STATES > 0) ? WAIT_W'(WAIT_STATES - 1) : '0;
    localparam logic [1:0] c_ACCEPT_NEXT = (WAIT_STATES == 0) ? c_ST_BURST : c_ST_WAIT;

    logic [1:0]        r_state;
    logic [LINE_W-1:0] r_line_base;
    logic [OFFS_W-1:0] r_offset;
    logic [WAIT_W-1:0] r_wait;
    logic              r_ready;

    logic              w_rd_en;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_unused_word_bits;

    // A read is only issued while the requester still holds mreq, so a drop stops delivery at once.
    assign w_rd_en   = clk_en && (r_state == c_ST_BURST) && mreq;
    assign w_wr_en   = clk_en && (r_state == c_ST_IDLE) && prog_we;
    assign w_rd_addr = {r_line_base, r_offset};

    assign w_unused_word_bits = ^address_in[OFFS_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_line_base <= '0;
            r_offset    <= '0;
            r_wait      <= '0;
            r_ready     <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                c_ST_IDLE: begin
                    r_ready <= 1'b0;
                    if (mreq) begin
                        r_line_base <= address_in[ADDR_W-1:OFFS_W];
                        r_offset    <= '0;
                        r_wait      <= '0;
                        r_state     <= c_ACCEPT_NEXT;
                    end
                end
                c_ST_WAIT: begin
                    if (!mreq) begin
                        r_state <= c_ST_IDLE;
                    end else if (r_wait == c_WAIT_LAST) begin
                        r_state <= c_ST_BURST;
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                c_ST_BURST: begin
                    if (!mreq) begin
                        r_state <= c_ST_IDLE;
                        r_ready <= 1'b0;
                    end else begin
                        r_ready  <= 1'b1;
                        r_offset <= r_offset + 3'd1;
                        if (r_offset == c_LAST_OFFS) begin
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_ready <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    imem_ram u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (prog_addr),
        .i_wr_data (prog_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (data_out)
    );

    assign ready = r_ready;
    assign busy  = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_imem_responder
// Description : Self-checking bench; two instances (0 and 3 wait states)
//               share stimulus, expectations come from a word-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        mreq = 1'b0;
    logic [9:0]  address_in = '0;
    logic        prog_we = 1'b0;
    logic [9:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;

    logic [15:0] data_out0, data_out3;
    logic        ready0, ready3, busy0, busy3;

    int tests = 0;
    int fails = 0;

    logic [15:0] model_mem [0:1023];

    imem_responder #(.WAIT_STATES(0), .LINE_WORDS(8)) dut0 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .mreq(mreq), .address_in(address_in),
        .data_out(data_out0), .ready(ready0), .busy(busy0),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    imem_responder #(.WAIT_STATES(3), .LINE_WORDS(8)) dut3 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .mreq(mreq), .address_in(address_in),
        .data_out(data_out3), .ready(ready3), .busy(busy3),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b0; mreq = 1'b1;
        tick(); tick();
        tests++;
        if (ready0 !== 1'b0 || busy0 !== 1'b0 || data_out0 !== 16'h0000) begin
            fails++;
            $display("FAIL reset_ws0: ready/busy/data_out %b/%b/%h, required 0/0/0000", ready0, busy0, data_out0);
        end
        tests++;
        if (ready3 !== 1'b0 || busy3 !== 1'b0 || data_out3 !== 16'h0000) begin
            fails++;
            $display("FAIL reset_ws3: ready/busy/data_out %b/%b/%h, required 0/0/0000", ready3, busy3, data_out3);
        end
        rst = 1'b0; mreq = 1'b0; clk_en = 1'b1;
        tick();
    endtask

    task automatic preload();
        for (int i = 0; i < 1024; i++) begin
            prog_we = 1'b1; prog_addr = 10'(i); prog_data = 16'hA000 + 16'(i);
            model_mem[i] = 16'hA000 + 16'(i);
            tick();
        end
        prog_we = 1'b0;
        tick();
    endtask

    // Runs one line request and checks words, first-ready cycle and return to idle.
    // drop_n < 8 lowers mreq in the cycle the drop_n-th word is seen;
    // stall_after > 0 holds clk_en low for two edges after that many words;
    // prog_cyc == 0 writes together with the request, > 0 writes mid-transfer.
    task automatic run_xfer(input string name, input bit sel3, input logic [9:0] addr,
                            input int drop_n, input int stall_after, input int prog_cyc,
                            input logic [9:0] paddr, input logic [15:0] pdata);
        int          ws;
        int          n_exp;
        int          idle_exp;
        int          first_cyc;
        int          idle_cyc;
        int          stall_left;
        bit          stalled;
        bit          en_prev;
        logic        r, b, hr;
        logic [15:0] d, hd;
        logic [15:0] got [$];
        logic [9:0]  waddr;
        ws        = sel3 ? 3 : 0;
        n_exp     = (drop_n < 8) ? drop_n : 8;
        idle_exp  = (drop_n < 8) ? ws + drop_n + 2 : ws + 10 + ((stall_after > 0) ? 2 : 0);
        first_cyc = -1;
        idle_cyc  = -1;
        stall_left = 0;
        stalled   = 1'b0;
        hr = 1'b0; hd = '0;
        if (prog_cyc == 0) model_mem[paddr] = pdata;

        mreq = 1'b1; address_in = addr;
        prog_we = (prog_cyc == 0); prog_addr = paddr; prog_data = pdata;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            en_prev = clk_en;
            tick();
            address_in = 10'($urandom);
            prog_we = (cyc == prog_cyc);
            r = sel3 ? ready3 : ready0;
            b = sel3 ? busy3 : busy0;
            d = sel3 ? data_out3 : data_out0;
            if (en_prev) begin
                if (r === 1'b1) begin
                    got.push_back(d);
                    if (first_cyc < 0) first_cyc = cyc;
                end
                if (b === 1'b0 && idle_cyc < 0) idle_cyc = cyc;
            end else begin
                tests++;
                if (r !== hr || d !== hd) begin
                    fails++;
                    $display("FAIL %s freeze c%0d: ready/data_out %b/%h, required held %b/%h", name, cyc, r, d, hr, hd);
                end
            end
            hr = r; hd = d;
            if (got.size() >= n_exp) mreq = 1'b0;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) clk_en = 1'b1;
            end else if (!stalled && stall_after > 0 && en_prev && r === 1'b1 && got.size() == stall_after) begin
                clk_en = 1'b0; stall_left = 2; stalled = 1'b1;
            end
        end
        mreq = 1'b0; clk_en = 1'b1; prog_we = 1'b0;

        tests++;
        if (got.size() != n_exp) begin
            fails++;
            $display("FAIL %s word_count: got %0d words, required %0d", name, got.size(), n_exp);
        end
        tests++;
        if (first_cyc != ws + 2) begin
            fails++;
            $display("FAIL %s first_ready: cycle %0d, required %0d", name, first_cyc, ws + 2);
        end
        tests++;
        if (idle_cyc != idle_exp) begin
            fails++;
            $display("FAIL %s idle_return: cycle %0d, required %0d", name, idle_cyc, idle_exp);
        end
        for (int k = 0; k < n_exp && k < got.size(); k++) begin
            waddr = {addr[9:3], 3'(k)};
            tests++;
            if (got[k] !== model_mem[waddr]) begin
                fails++;
                $display("FAIL %s word%0d: data_out %h, required %h", name, k, got[k], model_mem[waddr]);
            end
        end
        tick();
    endtask

    task automatic test_basic();
        run_xfer("basic_ws0", 1'b0, 10'h01B, 8, 0, -1, '0, '0);
    endtask

    task automatic test_wait_states();
        run_xfer("ws3", 1'b1, 10'h3F8, 8, 0, -1, '0, '0);
    endtask

    task automatic test_abort();
        run_xfer("abort_ws0", 1'b0, 10'h100, 3, 0, -1, '0, '0);
        run_xfer("abort_ws3", 1'b1, 10'h2C4, 3, 0, -1, '0, '0);
    endtask

    task automatic test_reset_mid_burst();
        mreq = 1'b1; address_in = 10'h040;
        tick(); tick(); tick(); tick();
        rst = 1'b1; clk_en = 1'b0; mreq = 1'b0;
        tick();
        tests++;
        if (ready0 !== 1'b0 || busy0 !== 1'b0 || data_out0 !== 16'h0000) begin
            fails++;
            $display("FAIL rst_mid_burst: ready/busy/data_out %b/%b/%h, required 0/0/0000", ready0, busy0, data_out0);
        end
        rst = 1'b0; clk_en = 1'b1;
        tick(); tick();
        tests++;
        if (ready0 !== 1'b0 || busy0 !== 1'b0) begin
            fails++;
            $display("FAIL rst_no_resume: ready/busy %b/%b, required 0/0", ready0, busy0);
        end
        run_xfer("after_rst", 1'b0, 10'h040, 8, 0, -1, '0, '0);
    endtask

    task automatic test_clk_en_stall();
        run_xfer("stall_ws0", 1'b0, 10'h0A5, 8, 3, -1, '0, '0);
        run_xfer("stall_ws3", 1'b1, 10'h311, 8, 6, -1, '0, '0);
    endtask

    task automatic test_prog();
        run_xfer("prog_busy", 1'b0, 10'h1B0, 8, 0, 3, 10'h020, 16'h1234);
        run_xfer("prog_old", 1'b0, 10'h020, 8, 0, -1, '0, '0);
        run_xfer("prog_idle", 1'b0, 10'h020, 8, 0, 0, 10'h020, 16'h1234);
    endtask

    task automatic test_random();
        int          mode;
        int          drop_n;
        int          stall_after;
        int          prog_cyc;
        logic [9:0]  addr;
        logic [9:0]  paddr;
        bit          sel3;
        for (int i = 0; i < 8; i++) begin
            sel3        = 1'($urandom);
            addr        = 10'($urandom);
            mode        = $urandom_range(0, 2);
            drop_n      = (mode == 1) ? $urandom_range(1, 7) : 8;
            stall_after = (mode == 2) ? $urandom_range(1, 7) : 0;
            prog_cyc    = ($urandom_range(0, 1) == 0) ? 0 : -1;
            paddr       = {addr[9:3], 3'($urandom)};
            run_xfer("random", sel3, addr, drop_n, stall_after, prog_cyc, paddr, 16'($urandom));
        end
    endtask

    initial begin
        test_reset();
        preload();
        test_basic();
        test_wait_states();
        test_abort();
        test_reset_mid_burst();
        test_clk_en_stall();
        test_prog();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter WAIT_STATES, default 0, sets idle cycles between accepting a line request and the first data word; legal range 0..7.
REQ-002 Parameter LINE_WORDS, default 8, sets words per cache line; fixed at 8 in this revision.
REQ-003 Port clk  input  1  sole clock; every register updates on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port clk_en  input  1  global clock enable; when low, all state holds.
REQ-006 Port mreq  input  1  line-fill request from the instruction cache.
REQ-007 Port address_in  input  10  word address from the cache; bits [9:3] select the line.
REQ-008 Port data_out  output  16  instruction word returned to the cache.
REQ-009 Port ready  output  1  data_out holds a valid burst word this cycle.
REQ-010 Port busy  output  1  a line transfer is in progress (state other than IDLE).
REQ-011 Port prog_we  input  1  program-load write strobe.
REQ-012 Port prog_addr  input  10  program-load word address.
REQ-013 Port prog_data  input  16  program-load write data.

Function
REQ-014 The block SHALL hold 1024x16 words of program memory with a one-cycle synchronous read.
REQ-015 The FSM SHALL have four states: IDLE, WAIT, BURST, DONE.
REQ-016 In IDLE with mreq=1 and clk_en=1, the block SHALL latch line_base=address_in[9:3], clear the 3-bit word offset and wait counter, and go to WAIT; if WAIT_STATES=0 it goes straight to BURST.
REQ-017 WAIT SHALL count WAIT_STATES cycles, then go to BURST; ready=0 throughout.
REQ-018 In BURST, the block SHALL issue a RAM read at {line_base, offset} on each cycle and increment the offset modulo 8.
REQ-019 ready SHALL be 1 exactly one cycle after each BURST read, with data_out equal to that word; words are delivered in offset order 0..7.
REQ-020 After the read at offset 7, the FSM SHALL go to DONE. DONE SHALL last one cycle, during which ready=1 for word 7, and then return to IDLE.
REQ-021 Request-to-first-ready latency SHALL be WAIT_STATES+2 cycles; a full transfer SHALL occupy WAIT_STATES+10 cycles from acceptance to return to IDLE.
REQ-022 If mreq drops in WAIT or BURST, the block SHALL abort to IDLE on the next edge, with ready=0 from the following cycle and no further words delivered.
REQ-023 Changes to address_in after acceptance SHALL be ignored until the block returns to IDLE.
REQ-024 When clk_en=0, state, counters, data_out and ready SHALL hold; RAM writes SHALL be suppressed.
REQ-025 A prog_we write SHALL occur only in IDLE; prog_we in any other state SHALL be dropped silently.
REQ-026 If prog_we and mreq are both asserted in IDLE, the write SHALL complete and the request SHALL be accepted in the same cycle; the burst SHALL read the newly written data.
REQ-027 data_out SHALL retain its last value when ready=0.

Reset
REQ-028 rst=1 SHALL force state=IDLE, offset=0, wait counter=0, ready=0, busy=0, data_out=0, regardless of clk_en.
REQ-029 Reset mid-burst SHALL abort the transfer with no further ready pulses.
REQ-030 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-031 A shared package SHALL define the FSM state enum, ADDR_W=10, DATA_W=16, LINE_WORDS=8 and OFFS_W=3.
REQ-032 The memory array SHALL live in a sub-module imem_ram (1R1W, synchronous read, read-old-data on same-address collision); the FSM SHALL stay in imem_responder.

Verification
REQ-033 Preload word n = 16'hA000+n, WAIT_STATES=0, mreq with address_in=10'h01B -> ready pulses on cycles 2..9 carrying 16'hA018..16'hA01F in order; busy returns to 0 at cycle 10.
REQ-034 WAIT_STATES=3, address_in=10'h3F8 -> first ready at cycle 5, eight words 16'hA3F8..16'hA3FF, wrap to offset 0 not exceeded.
REQ-035 Drop mreq after the third ready -> exactly 3 words delivered, then IDLE and ready=0.
REQ-036 Assert rst during BURST -> next cycle ready=0, busy=0, data_out=0; a new request then completes normally.
REQ-037 Toggle clk_en low for 2 cycles mid-burst -> ready and data_out frozen; word sequence resumes with no skips or duplicates.
REQ-038 prog_we to 10'h020 with 16'h1234 during BURST -> write dropped (later read returns old value); the same write in IDLE together with mreq at 10'h020 -> word 0 of the burst = 16'h1234.
